// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: datapath widths and the writeback/load
// encodings used by the stage registers, the register file and forwarding.
package pipe_pkg;

    localparam int XLEN = 32;
    localparam int REGW = 5;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_PC4 = 2'd2,
        WB_IMM = 2'd3
    } wb_sel_e;

    // Encodings 5-7 are not named; consumers treat them as LD_W.
    typedef enum logic [2:0] {
        LD_B  = 3'd0,
        LD_BU = 3'd1,
        LD_H  = 3'd2,
        LD_HU = 3'd3,
        LD_W  = 3'd4
    } ld_type_e;

endpackage

// File: rtl/load_ext.sv
// Load formatter: picks the addressed byte or halfword out of the memory
// word and sign- or zero-extends it; words pass through untouched.
module load_ext #(
    parameter int XLEN = pipe_pkg::XLEN
) (
    input  logic [XLEN-1:0] in_mem,
    input  logic [2:0]      in_ld_type,
    input  logic [1:0]      in_addr_lo,
    output logic [XLEN-1:0] ld_data
);
    import pipe_pkg::*;

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Halfword select uses only addr_lo[1]; a misaligned low bit is ignored.
    always_comb begin
        byte_sel = in_mem[{in_addr_lo, 3'b000} +: 8];
        half_sel = in_mem[{in_addr_lo[1], 4'b0000} +: 16];
        ld_data  = in_mem;
        case (in_ld_type)
            LD_B:    ld_data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            LD_BU:   ld_data = {{(XLEN-8){1'b0}}, byte_sel};
            LD_H:    ld_data = {{(XLEN-16){half_sel[15]}}, half_sel};
            LD_HU:   ld_data = {{(XLEN-16){1'b0}}, half_sel};
            default: ld_data = in_mem;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// MEM/WB stage register: formats and selects the writeback value, drives the
// register-file write port from flops and counts retired instructions.
module wb_stage #(
    parameter int XLEN = pipe_pkg::XLEN,
    parameter int REGW = pipe_pkg::REGW
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall_i,
    input  logic            flush_i,
    input  logic            in_valid,
    input  logic [REGW-1:0] in_rd,
    input  logic            in_rf_we,
    input  logic [1:0]      in_wb_sel,
    input  logic [2:0]      in_ld_type,
    input  logic [1:0]      in_addr_lo,
    input  logic [XLEN-1:0] in_alu,
    input  logic [XLEN-1:0] in_mem,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_imm,
    output logic [REGW-1:0] wb_rd,
    output logic [XLEN-1:0] wb_wd,
    output logic            wb_we,
    output logic            wb_valid,
    output logic [XLEN-1:0] wb_pc,
    output logic [63:0]     instret
);
    import pipe_pkg::*;

    logic [XLEN-1:0] ld_fmt;
    logic [XLEN-1:0] sel_wd;

    logic            valid_d,   valid_q;
    logic            we_d,      we_q;
    logic [REGW-1:0] rd_d,      rd_q;
    logic [XLEN-1:0] wd_d,      wd_q;
    logic [XLEN-1:0] pc_d,      pc_q;
    logic [63:0]     instret_d, instret_q;

    load_ext #(.XLEN(XLEN)) u_load_ext (
        .in_mem     (in_mem),
        .in_ld_type (in_ld_type),
        .in_addr_lo (in_addr_lo),
        .ld_data    (ld_fmt)
    );

    always_comb begin
        sel_wd = in_alu;
        case (in_wb_sel)
            WB_ALU:  sel_wd = in_alu;
            WB_MEM:  sel_wd = ld_fmt;
            WB_PC4:  sel_wd = in_pc + XLEN'(4);
            WB_IMM:  sel_wd = in_imm;
            default: sel_wd = in_alu;
        endcase
    end

    // Flush beats stall; a flush clears only valid/we and leaves the payload.
    always_comb begin
        valid_d   = valid_q;
        we_d      = we_q;
        rd_d      = rd_q;
        wd_d      = wd_q;
        pc_d      = pc_q;
        instret_d = instret_q;
        if (flush_i) begin
            valid_d = 1'b0;
            we_d    = 1'b0;
        end else if (!stall_i) begin
            valid_d = in_valid;
            we_d    = in_valid & in_rf_we & (in_rd != '0);
            rd_d    = in_rd;
            wd_d    = sel_wd;
            pc_d    = in_pc;
            if (in_valid) begin
                instret_d = instret_q + 64'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            we_q      <= 1'b0;
            rd_q      <= '0;
            wd_q      <= '0;
            pc_q      <= '0;
            instret_q <= '0;
        end else begin
            valid_q   <= valid_d;
            we_q      <= we_d;
            rd_q      <= rd_d;
            wd_q      <= wd_d;
            pc_q      <= pc_d;
            instret_q <= instret_d;
        end
    end

    assign wb_valid = valid_q;
    assign wb_we    = we_q;
    assign wb_rd    = rd_q;
    assign wb_wd    = wd_q;
    assign wb_pc    = pc_q;
    assign instret  = instret_q;

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: hand-computed writeback values, stall/flush
// priority, rd=0 suppression and asynchronous reset behaviour.
module tb_wb_stage;
    import pipe_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        stall_i;
    logic        flush_i;
    logic        in_valid;
    logic [4:0]  in_rd;
    logic        in_rf_we;
    logic [1:0]  in_wb_sel;
    logic [2:0]  in_ld_type;
    logic [1:0]  in_addr_lo;
    logic [31:0] in_alu;
    logic [31:0] in_mem;
    logic [31:0] in_pc;
    logic [31:0] in_imm;
    logic [4:0]  wb_rd;
    logic [31:0] wb_wd;
    logic        wb_we;
    logic        wb_valid;
    logic [31:0] wb_pc;
    logic [63:0] instret;

    int vectors;
    int miscompares;

    wb_stage dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .stall_i    (stall_i),
        .flush_i    (flush_i),
        .in_valid   (in_valid),
        .in_rd      (in_rd),
        .in_rf_we   (in_rf_we),
        .in_wb_sel  (in_wb_sel),
        .in_ld_type (in_ld_type),
        .in_addr_lo (in_addr_lo),
        .in_alu     (in_alu),
        .in_mem     (in_mem),
        .in_pc      (in_pc),
        .in_imm     (in_imm),
        .wb_rd      (wb_rd),
        .wb_wd      (wb_wd),
        .wb_we      (wb_we),
        .wb_valid   (wb_valid),
        .wb_pc      (wb_pc),
        .instret    (instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Drives one MEM-stage bundle, then waits past the next rising edge.
    task automatic applyStimulus(input logic v, input logic we, input logic [4:0] rd,
                                 input logic [1:0] sel, input logic [2:0] ld,
                                 input logic [1:0] a, input logic [31:0] alu,
                                 input logic [31:0] mem, input logic [31:0] pc,
                                 input logic [31:0] imm);
        in_valid   = v;
        in_rf_we   = we;
        in_rd      = rd;
        in_wb_sel  = sel;
        in_ld_type = ld;
        in_addr_lo = a;
        in_alu     = alu;
        in_mem     = mem;
        in_pc      = pc;
        in_imm     = imm;
        @(posedge clk);
        #1;
    endtask

    logic [2:0]  ld_tab   [6];
    logic [1:0]  addr_tab [6];
    logic [31:0] exp_tab  [6];

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n   = 1'b0;
        stall_i = 1'b0;
        flush_i = 1'b0;
        in_valid = 1'b0; in_rf_we = 1'b0; in_rd = '0; in_wb_sel = '0;
        in_ld_type = '0; in_addr_lo = '0;
        in_alu = '0; in_mem = '0; in_pc = '0; in_imm = '0;

        ld_tab[0] = LD_B;  addr_tab[0] = 2'd0; exp_tab[0] = 32'hFFFF_FF82;
        ld_tab[1] = LD_BU; addr_tab[1] = 2'd0; exp_tab[1] = 32'h0000_0082;
        ld_tab[2] = LD_B;  addr_tab[2] = 2'd1; exp_tab[2] = 32'h0000_007F;
        ld_tab[3] = LD_H;  addr_tab[3] = 2'd2; exp_tab[3] = 32'hFFFF_80F1;
        ld_tab[4] = LD_HU; addr_tab[4] = 2'd3; exp_tab[4] = 32'h0000_80F1;
        ld_tab[5] = LD_W;  addr_tab[5] = 2'd2; exp_tab[5] = 32'h80F1_7F82;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_valid", {63'd0, wb_valid}, 64'd0);
        checkOutput("rst_we", {63'd0, wb_we}, 64'd0);
        checkOutput("rst_rd", {59'd0, wb_rd}, 64'd0);
        checkOutput("rst_wd", {32'd0, wb_wd}, 64'd0);
        checkOutput("rst_pc", {32'd0, wb_pc}, 64'd0);
        checkOutput("rst_instret", instret, 64'd0);
        rst_n = 1'b1;

        for (int i = 1; i <= 3; i++) begin
            applyStimulus(1'b1, 1'b1, 5'(i), WB_ALU, LD_W, 2'd0, 32'h11 * i,
                          32'h0, 32'h100 + 32'(4 * i), 32'h0);
            checkOutput("alu_we", {63'd0, wb_we}, 64'd1);
            checkOutput("alu_rd", {59'd0, wb_rd}, 64'(i));
            checkOutput("alu_wd", {32'd0, wb_wd}, 64'(32'h11 * i));
        end
        checkOutput("alu_pc", {32'd0, wb_pc}, 64'h10C);
        checkOutput("alu_instret", instret, 64'd3);

        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, 1'b1, 5'd4, WB_MEM, ld_tab[i], addr_tab[i],
                          32'hDEAD_BEEF, 32'h80F1_7F82, 32'h200, 32'h0);
            checkOutput($sformatf("load%0d_wd", i), {32'd0, wb_wd}, {32'd0, exp_tab[i]});
        end
        checkOutput("load_instret", instret, 64'd9);

        applyStimulus(1'b1, 1'b1, 5'd6, WB_PC4, LD_W, 2'd0, 32'h1, 32'h2,
                      32'hFFFF_FFFC, 32'h3);
        checkOutput("pc4_wd", {32'd0, wb_wd}, 64'd0);
        checkOutput("pc4_pc", {32'd0, wb_pc}, 64'hFFFF_FFFC);
        applyStimulus(1'b1, 1'b1, 5'd7, WB_IMM, LD_W, 2'd0, 32'h1, 32'h2,
                      32'h300, 32'h1234_5000);
        checkOutput("imm_wd", {32'd0, wb_wd}, 64'h1234_5000);
        checkOutput("imm_instret", instret, 64'd11);

        applyStimulus(1'b1, 1'b1, 5'd5, WB_ALU, LD_W, 2'd0, 32'hAA, 32'h0,
                      32'h400, 32'h0);
        checkOutput("pre_stall_instret", instret, 64'd12);
        stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b1, 5'd9, WB_ALU, LD_W, 2'd0, 32'h55, 32'h0,
                          32'h500, 32'h0);
            checkOutput("stall_rd", {59'd0, wb_rd}, 64'd5);
            checkOutput("stall_wd", {32'd0, wb_wd}, 64'hAA);
            checkOutput("stall_we", {63'd0, wb_we}, 64'd1);
            checkOutput("stall_pc", {32'd0, wb_pc}, 64'h400);
            checkOutput("stall_instret", instret, 64'd12);
        end
        flush_i = 1'b1;
        applyStimulus(1'b1, 1'b1, 5'd9, WB_ALU, LD_W, 2'd0, 32'h55, 32'h0,
                      32'h500, 32'h0);
        checkOutput("flush_valid", {63'd0, wb_valid}, 64'd0);
        checkOutput("flush_we", {63'd0, wb_we}, 64'd0);
        checkOutput("flush_instret", instret, 64'd12);
        flush_i = 1'b0;
        stall_i = 1'b0;

        applyStimulus(1'b1, 1'b1, 5'd0, WB_ALU, LD_W, 2'd0, 32'h77, 32'h0,
                      32'h600, 32'h0);
        checkOutput("rd0_we", {63'd0, wb_we}, 64'd0);
        checkOutput("rd0_valid", {63'd0, wb_valid}, 64'd1);
        checkOutput("rd0_instret", instret, 64'd13);

        applyStimulus(1'b0, 1'b1, 5'd6, WB_ALU, LD_W, 2'd0, 32'h66, 32'h0,
                      32'h700, 32'h0);
        checkOutput("bubble_we", {63'd0, wb_we}, 64'd0);
        checkOutput("bubble_valid", {63'd0, wb_valid}, 64'd0);
        checkOutput("bubble_instret", instret, 64'd13);

        applyStimulus(1'b1, 1'b0, 5'd8, WB_ALU, LD_W, 2'd0, 32'h88, 32'h0,
                      32'h800, 32'h0);
        checkOutput("nowe_we", {63'd0, wb_we}, 64'd0);
        checkOutput("nowe_instret", instret, 64'd14);

        applyStimulus(1'b1, 1'b1, 5'd9, WB_ALU, LD_W, 2'd0, 32'h99, 32'h0,
                      32'h900, 32'h0);
        checkOutput("prereset_we", {63'd0, wb_we}, 64'd1);
        checkOutput("prereset_instret", instret, 64'd15);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_we", {63'd0, wb_we}, 64'd0);
        checkOutput("async_valid", {63'd0, wb_valid}, 64'd0);
        checkOutput("async_wd", {32'd0, wb_wd}, 64'd0);
        checkOutput("async_instret", instret, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(1'b1, 1'b1, 5'd3, WB_IMM, LD_W, 2'd0, 32'h0, 32'h0,
                      32'hA00, 32'hCAFE_0000);
        checkOutput("post_reset_wd", {32'd0, wb_wd}, 64'hCAFE_0000);
        checkOutput("post_reset_instret", instret, 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/wb_stage.md
# wb_stage

MEM/WB pipeline register and writeback selector for the 5-stage core. Captures the result bundle leaving the memory stage, selects and formats the writeback value, and drives the register file's write port (`wR`, `wD`, `we`) from registered outputs. Also maintains the retired-instruction counter.

## Interface
- `XLEN`, 32: datapath width.
- `REGW`, 5: register index width.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `stall_i`  in  1  hold the stage register.
- `flush_i`  in  1  load a bubble.
- `in_valid`  in  1  MEM-stage bundle is a real instruction.
- `in_rd`  in  REGW  destination register.
- `in_rf_we`  in  1  instruction writes `rd`.
- `in_wb_sel`  in  2  writeback source: 0 ALU, 1 MEM, 2 PC+4, 3 IMM.
- `in_ld_type`  in  3  0 LB, 1 LBU, 2 LH, 3 LHU, 4 LW; 5–7 are treated as LW.
- `in_addr_lo`  in  2  low bits of the load address.
- `in_alu`, `in_mem`, `in_pc`, `in_imm`  in  XLEN each  candidate sources.
- `wb_rd`  out  REGW  to RF `wR`.
- `wb_wd`  out  XLEN  to RF `wD`.
- `wb_we`  out  1  to RF `we`.
- `wb_valid`  out  1  stage holds a real instruction.
- `wb_pc`  out  XLEN  PC of the held instruction, for debug and trace.
- `instret`  out  64  retired-instruction count.

## Operation
- Writeback value is computed combinationally from the `in_*` signals, then registered, so every output is a flop.
- Source selection:
  - ALU selects `in_alu`.
  - MEM selects the load-formatted `in_mem`.
  - PC+4 selects `in_pc + 4` (modulo 2^XLEN).
  - IMM selects `in_imm`.
- Load formatting:
  - LB/LBU take byte `in_addr_lo`, i.e. bits [8*a+7:8*a].
  - LH/LHU take halfword `in_addr_lo[1]`; `in_addr_lo[0]` is ignored.
  - LB and LH sign-extend; LBU and LHU zero-extend.
  - LW passes `in_mem` unchanged and ignores `in_addr_lo`.
- Register update priority on each edge: `flush_i` > `stall_i` > load.
  - Flush: `wb_valid` ← 0 and `wb_we` ← 0. Other fields are don't-care but are held.
  - Stall: all stage flops hold.
  - Load: the stage captures the new bundle. `wb_valid` ← `in_valid`; `wb_we` ← `in_valid & in_rf_we & (in_rd != 0)`.
- `instret` increments by 1 on every edge where a load occurs with `in_valid`=1 (i.e. no flush, no stall). It wraps at 2^64.
- While stalled, the RF write repeats with the same value; this is benign, and `instret` does not count again.

## Timing
- Latency 1 cycle from the `in_*` signals to the `wb_*` signals. The RF commits on the following edge, so the total is 2 edges from MEM to architectural state.
- Reset (async assert, sync release): `wb_valid`=0, `wb_we`=0, `wb_rd`=0, `wb_wd`=0, `wb_pc`=0, `instret`=0.
- Reset asserted mid-operation forces `wb_we`=0 immediately, so no partial write reaches the RF.
- `flush_i` and `stall_i` asserted together: flush wins, a bubble is loaded, and there is no `instret` increment.
- `in_rd`=0 with `in_rf_we`=1: the instruction still retires and counts, but `wb_we`=0.
- No combinational path from any input to any output.

## Structure
- Shared package `pipe_pkg` holds:
  - enum `wb_sel_e` (WB_ALU, WB_MEM, WB_PC4, WB_IMM);
  - enum `ld_type_e` (LD_B, LD_BU, LD_H, LD_HU, LD_W);
  - `XLEN` and `REGW` constants reused by the RF and the other stage registers.
- One sub-module, `load_ext`: combinational byte/half select and extend. Inputs are `in_mem`, `in_ld_type` and `in_addr_lo`; output is the formatted XLEN word. Reused later by the forwarding path.

## Test plan
- Reset released, 3 ALU instructions with rd=1,2,3, wd=0x11,0x22,0x33 → one cycle later `wb_we`=1 each cycle with matching rd/wd; `instret`=3.
- MEM with `in_mem`=0x80F1_7F82:
  - LB at addr_lo=0 → 0xFFFF_FF82.
  - LBU at addr_lo=0 → 0x0000_0082.
  - LB at addr_lo=1 → 0x0000_007F.
  - LH at addr_lo=2 → 0xFFFF_80F1.
  - LHU at addr_lo=3 → 0x0000_80F1.
  - LW → 0x80F1_7F82.
- PC+4 with `in_pc`=0xFFFF_FFFC → `wb_wd`=0; IMM 0x1234_5000 → `wb_wd`=0x1234_5000.
- Stall for 3 cycles after a valid ALU instruction (rd=5, wd=0xAA) → outputs held, `instret` +1 only; then flush and stall together → `wb_valid`=0, `wb_we`=0, `instret` unchanged.
- `in_rd`=0, `in_rf_we`=1, valid → `wb_we`=0, `instret` +1.
- Assert `rst_n`=0 asynchronously between edges while `wb_we`=1 → `wb_we` and `instret` go to 0 before the next edge.
